tmc_onchip_mem_master: RTL



---
 rtl/tmc_onchip_mem_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tmc_onchip_mem_master.sv
// Avalon-MM master that streams word runs into or out of a single-port
// on-chip RAM (read latency 1). Read data lands in a 2-entry first-word
// fall-through skid FIFO so the output stream can stall without losing reads.
module tmc_onchip_mem_master #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [ADDR_W:0]       i_cmd_len,
  input  logic [DATA_W-1:0]     i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [DATA_W-1:0]     o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_W-1:0]     o_address,
  output logic [DATA_W/8-1:0]   o_byteenable,
  output logic                  o_chipselect,
  output logic                  o_write,
  output logic [DATA_W-1:0]     o_writedata,
  output logic                  o_clken,
  input  logic [DATA_W-1:0]     i_readdata
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OCC_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  w_rem_nxt;
  logic              r_inflight;
  logic              w_inflight_nxt;

  logic [1:0]        r_fifo_cnt;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [DATA_W-1:0] r_fifo_mem [2];

  logic              w_pop;
  logic              w_push;
  logic              w_wr_fire;
  logic              w_rd_issue;
  logic [OCC_W-1:0]  w_occ;

  // FIFO handshakes; a read issued last cycle always returns data this cycle
  assign w_pop  = (r_fifo_cnt != 2'd0) && i_out_ready;
  assign w_push = r_inflight;

  // Words held or pending after this cycle's pop; must stay below FIFO depth
  assign w_occ      = OCC_W'(r_fifo_cnt) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_rd_issue = (r_state == S_READ) && (w_occ < OCC_W'(2));
  assign w_wr_fire  = (r_state == S_WRITE) && i_in_valid;

  // Stream and bus payload paths
  assign o_out_data   = r_fifo_mem[r_rd_ptr];
  assign o_out_valid  = (r_fifo_cnt != 2'd0);
  assign o_writedata  = i_in_data;
  assign o_address    = r_addr;
  assign o_byteenable = {BE_W{1'b1}};
  assign o_clken      = 1'b1;

  // Next-state, run counters and control outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_rem_nxt      = r_rem;
    w_inflight_nxt = w_rd_issue;
    o_cmd_ready    = 1'b0;
    o_busy         = 1'b1;
    o_done         = 1'b0;
    o_in_ready     = 1'b0;
    o_chipselect   = w_wr_fire || w_rd_issue;
    o_write        = w_wr_fire;

    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_cmd_valid) begin
          w_addr_nxt = i_cmd_addr;
          w_rem_nxt  = i_cmd_len;
          if (i_cmd_len == LEN_W'(0)) begin
            w_state_nxt = S_DONE;
          end else if (i_cmd_write) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_WRITE: begin
        o_in_ready = 1'b1;
        if (w_wr_fire) begin
          w_addr_nxt = r_addr + ADDR_W'(1);
          w_rem_nxt  = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_READ: begin
        if (w_rd_issue) begin
          w_addr_nxt = r_addr + ADDR_W'(1);
          w_rem_nxt  = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!r_inflight && (r_fifo_cnt == 2'd1) && w_pop) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and run registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_rem      <= w_rem_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  // FIFO occupancy and pointers; reset discards any buffered words
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_fifo_cnt <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  // FIFO storage; contents are don't-care while the count is zero
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= i_readdata;
    end
  end

endmodule
